fifo_reorder: RTL and testbench
===============================

// Module: fifo_reorder
// PURPOSE
// - Reorder buffer for split transactions: allocates IDs in order, accepts results by ID in
//   any order, and releases them in allocation order.
// - Used by MMIO bridges where the core stamps each outgoing network request with an ID.
//   Responses or credits return out of order over the network, and core responses are
//   released strictly in order.
// PARAMETERS
// - width_p  32  data width of each entry, in bits.
// - els_p    32  number of entries and outstanding IDs; any value >= 2.
// - id_w = `BSG_SAFE_CLOG2(els_p)  (derived, not overridable).
// PORTS
// - clk_i              in   1        clock, rising edge.
// - reset_i            in   1        synchronous, active-high reset.
// - fifo_alloc_id_o    out  id_w     next ID to allocate (the tail pointer).
// - fifo_alloc_v_o     out  1        an entry is free for allocation.
// - fifo_alloc_yumi_i  in   1        consumer takes fifo_alloc_id_o; legal only while fifo_alloc_v_o.
// - write_id_i         in   id_w     ID of the allocated entry being filled.
// - write_data_i       in   width_p  data for that entry.
// - write_v_i          in   1        write strobe; always accepted (no ready signal).
// - fifo_deq_data_o    out  width_p  data at the head entry.
// - fifo_deq_v_o       out  1        head entry is allocated and written.
// - fifo_deq_yumi_i    in   1        consumer takes the head; legal only while fifo_deq_v_o.
// - empty_o            out  1        no entries are allocated.
// BEHAVIOUR
// - State:
//   - rptr (head) and wptr (tail), both id_w bits wide, each wrapping from els_p-1 to 0.
//   - A full/empty discriminator (either a wrap bit per pointer or an occupancy counter
//     0..els_p).
//   - Per-entry valid bit, set when the entry is written.
//   - Data array of els_p x width_p.
// - Reset: rptr=wptr=0, occupancy 0, all valid bits 0. Outputs after reset:
//   fifo_alloc_v_o=1, fifo_alloc_id_o=0, fifo_deq_v_o=0, empty_o=1.
//   fifo_deq_data_o is don't-care while fifo_deq_v_o=0.
// - Allocate:
//   - fifo_alloc_v_o = (occupancy != els_p).
//   - On fifo_alloc_yumi_i: wptr++ and occupancy++. The entry's valid bit is already 0.
// - Write:
//   - On write_v_i: data[write_id_i] <= write_data_i and valid[write_id_i] <= 1.
//   - The write may target any allocated, not-yet-written entry, in any order.
// - Dequeue:
//   - fifo_deq_v_o = valid[rptr]; fifo_deq_data_o = data[rptr]. Both are combinational
//     from registered state.
//   - A write to the head entry makes fifo_deq_v_o rise on the next cycle. There is no
//     write-to-dequeue bypass.
//   - On fifo_deq_yumi_i: valid[rptr] <= 0, rptr++, occupancy--.
// - empty_o = (occupancy == 0). It is independent of the valid bits.
// - Simultaneous events:
//   - Alloc and deq in the same cycle: occupancy unchanged, both pointers advance.
//     This is legal when full only if deq frees a slot, but fifo_alloc_v_o is still 0
//     that cycle, so no alloc occurs.
//   - Write and deq in the same cycle target different entries and are both performed.
//   - Alloc, write and deq may all coincide.
// - Wrap-around: IDs recycle modulo els_p. After els_p allocations fifo_alloc_id_o
//   returns to 0.
// - The following are illegal and the behaviour is undefined:
//   - fifo_alloc_yumi_i while !fifo_alloc_v_o;
//   - fifo_deq_yumi_i while !fifo_deq_v_o;
//   - writing an unallocated ID;
//   - writing the same ID twice before it is dequeued.
// - Reset asserted mid-operation discards all entries. Its priority is over every other input.
// - No combinational path from any input to any output.
// CONFIGURATION
// - FIFO_REORDER_ASSERT_EN defined: simulation-only checks.
//   - Each illegal case listed above reports $error, naming the ID and the cycle.
//   - Checks are suppressed while reset_i=1.
// - Without the macro: no checks. Logic and behaviour are identical, and the block is
//   synthesizable either way.
// TESTING
// - Reset, then 4 allocs: IDs 0,1,2,3, empty_o goes 1->0, fifo_deq_v_o stays 0.
// - Write id2=0xC, id0=0xA, id3=0xD, id1=0xB (one per cycle):
//   - deq_v rises the cycle after id0 is written; 0xA is dequeued;
//   - deq_v drops until id1 is written; then 0xB, 0xC, 0xD are dequeued back to back;
//   - empty_o=1 at the end.
// - els_p=4, fill with 4 allocs: alloc_v=0. Write and deq id0: alloc_v=1 the next cycle
//   and fifo_alloc_id_o=0 (wrap).
// - Alloc, write and deq in the same cycle at steady state for 100 cycles (random data):
//   the output sequence equals the write sequence and occupancy stays constant.
// - Random out-of-order writes with backpressure on deq_yumi over 10k transactions:
//   output order equals allocation order against a scoreboard, with no loss or duplication.
// - With FIFO_REORDER_ASSERT_EN: writing an unallocated ID or dequeuing while empty raises $error.

Source files
------------

// File: rtl/fifo_reorder_if.sv
// fifo_reorder_if: allocate / write / dequeue signal bundle for the reorder buffer.
interface fifo_reorder_if #(parameter int width_p = 32, parameter int els_p = 32);
    localparam int id_w = $clog2(els_p);
    logic [id_w-1:0]    fifo_alloc_id_o;
    logic               fifo_alloc_v_o;
    logic               fifo_alloc_yumi_i;
    logic [id_w-1:0]    write_id_i;
    logic [width_p-1:0] write_data_i;
    logic               write_v_i;
    logic [width_p-1:0] fifo_deq_data_o;
    logic               fifo_deq_v_o;
    logic               fifo_deq_yumi_i;
    logic               empty_o;
    modport master (
        input  fifo_alloc_id_o, fifo_alloc_v_o, fifo_deq_data_o, fifo_deq_v_o, empty_o,
        output fifo_alloc_yumi_i, write_id_i, write_data_i, write_v_i, fifo_deq_yumi_i
    );
    modport slave (
        output fifo_alloc_id_o, fifo_alloc_v_o, fifo_deq_data_o, fifo_deq_v_o, empty_o,
        input  fifo_alloc_yumi_i, write_id_i, write_data_i, write_v_i, fifo_deq_yumi_i
    );
endinterface

// File: rtl/fifo_reorder.sv
// fifo_reorder: in-order ID allocation, out-of-order fill by ID, in-order release.
// Define FIFO_REORDER_ASSERT_EN for simulation-only illegal-usage checks.
module fifo_reorder #(
    parameter int width_p = 32,
    parameter int els_p   = 32
) (
    input logic           clk_i,
    input logic           reset_i,
    fifo_reorder_if.slave bus
);
    localparam int id_w  = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    logic [id_w-1:0]    r_rptr, r_wptr;
    logic [cnt_w-1:0]   r_cnt;
    logic [els_p-1:0]   r_valid;
    logic [width_p-1:0] r_data [els_p];

    wire w_alloc = bus.fifo_alloc_yumi_i;
    wire w_deq   = bus.fifo_deq_yumi_i;
    wire w_write = bus.write_v_i;

    // pointers wrap at els_p, which need not be a power of two
    function automatic logic [id_w-1:0] inc(input logic [id_w-1:0] p);
        return (p == id_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            if (w_alloc) r_wptr <= inc(r_wptr);
            if (w_deq) begin
                r_rptr          <= inc(r_rptr);
                r_valid[r_rptr] <= 1'b0;
            end
            if (w_write) r_valid[bus.write_id_i] <= 1'b1;
            r_cnt <= r_cnt + cnt_w'(w_alloc) - cnt_w'(w_deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_write) r_data[bus.write_id_i] <= bus.write_data_i;
    end

    assign bus.fifo_alloc_id_o = r_wptr;
    assign bus.fifo_alloc_v_o  = (r_cnt != cnt_w'(els_p));
    assign bus.fifo_deq_v_o    = r_valid[r_rptr];
    assign bus.fifo_deq_data_o = r_data[r_rptr];
    assign bus.empty_o         = (r_cnt == '0);

`ifdef FIFO_REORDER_ASSERT_EN
    logic [31:0] r_cyc;
    int          w_off;

    always_ff @(posedge clk_i) begin
        r_cyc <= reset_i ? '0 : r_cyc + 1;
    end

    // distance of the written ID from the head; allocated iff below occupancy
    always_comb begin
        w_off = (int'(bus.write_id_i) - int'(r_rptr) + els_p) % els_p;
    end

    always @(posedge clk_i) begin
        if (!reset_i) begin
            if (w_alloc && !bus.fifo_alloc_v_o)
                $error("fifo_reorder: alloc id %0d while full, cycle %0d", r_wptr, r_cyc);
            if (w_deq && !bus.fifo_deq_v_o)
                $error("fifo_reorder: deq id %0d while not valid, cycle %0d", r_rptr, r_cyc);
            if (w_write && (int'(bus.write_id_i) >= els_p || w_off >= int'(r_cnt)))
                $error("fifo_reorder: write of unallocated id %0d, cycle %0d", bus.write_id_i, r_cyc);
            else if (w_write && r_valid[bus.write_id_i])
                $error("fifo_reorder: second write of id %0d, cycle %0d", bus.write_id_i, r_cyc);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_reorder.sv
// tb_fifo_reorder: directed and scoreboard checks of fifo_reorder with els_p=4.
module tb_fifo_reorder;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errs = 0;

    always #5 clk = ~clk;

    fifo_reorder_if #(.width_p(W), .els_p(N)) bus();
    fifo_reorder #(.width_p(W), .els_p(N)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fifo_alloc_yumi_i = 1'b0;
        bus.write_v_i         = 1'b0;
        bus.fifo_deq_yumi_i   = 1'b0;
    endtask

    task automatic wr(input int id, input logic [31:0] d);
        bus.write_v_i    = 1'b1;
        bus.write_id_i   = 2'(id);
        bus.write_data_i = d;
    endtask

    logic [31:0] sd [0:101];
    logic [31:0] m_data [N];
    logic        m_valid [N];
    int m_head, m_tail, m_occ, deqs, cyc, e, wid;
    bit a, w, d;
    int cand[$];

    initial begin
        idle();
        bus.write_id_i   = '0;
        bus.write_data_i = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_alloc_v", bus.fifo_alloc_v_o, 1);
        check("rst_alloc_id", bus.fifo_alloc_id_o, 0);
        check("rst_deq_v", bus.fifo_deq_v_o, 0);
        check("rst_empty", bus.empty_o, 1);

        for (int i = 0; i < N; i++) begin
            check("alloc_id", bus.fifo_alloc_id_o, i);
            bus.fifo_alloc_yumi_i = 1'b1;
            tick();
            check("alloc_empty", bus.empty_o, 0);
            check("alloc_deq_v", bus.fifo_deq_v_o, 0);
        end
        idle();
        check("full_alloc_v", bus.fifo_alloc_v_o, 0);

        wr(2, 32'hC);
        tick();
        check("w2_deq_v", bus.fifo_deq_v_o, 0);
        wr(0, 32'hA);
        tick();
        check("w0_deq_v", bus.fifo_deq_v_o, 1);
        check("w0_data", bus.fifo_deq_data_o, 32'hA);
        check("w0_full", bus.fifo_alloc_v_o, 0);
        wr(3, 32'hD);
        bus.fifo_deq_yumi_i = 1'b1;
        tick();
        idle();
        check("wrap_alloc_v", bus.fifo_alloc_v_o, 1);
        check("wrap_alloc_id", bus.fifo_alloc_id_o, 0);
        check("gap_deq_v", bus.fifo_deq_v_o, 0);
        wr(1, 32'hB);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            check("drain_v", bus.fifo_deq_v_o, 1);
            check("drain_data", bus.fifo_deq_data_o, 32'hB + i);
            bus.fifo_deq_yumi_i = 1'b1;
            tick();
        end
        idle();
        check("end_empty", bus.empty_o, 1);
        check("end_deq_v", bus.fifo_deq_v_o, 0);

        // steady state: alloc id c, write id c-1, deq id c-2 each cycle
        for (int c = 0; c < 102; c++) begin
            sd[c] = $urandom;
            check("ss_alloc_id", bus.fifo_alloc_id_o, c % N);
            check("ss_alloc_v", bus.fifo_alloc_v_o, 1);
            bus.fifo_alloc_yumi_i = 1'b1;
            bus.write_v_i = 1'b0;
            if (c >= 1) wr((c - 1) % N, sd[c-1]);
            bus.fifo_deq_yumi_i = 1'b0;
            if (c >= 2) begin
                check("ss_deq_v", bus.fifo_deq_v_o, 1);
                check("ss_data", bus.fifo_deq_data_o, sd[c-2]);
                bus.fifo_deq_yumi_i = 1'b1;
            end
            tick();
            check("ss_empty", bus.empty_o, 0);
        end
        idle();

        rst = 1'b1;
        bus.fifo_alloc_yumi_i = 1'b1;
        tick();
        idle();
        rst = 1'b0;
        check("midrst_empty", bus.empty_o, 1);
        check("midrst_deq_v", bus.fifo_deq_v_o, 0);
        check("midrst_id", bus.fifo_alloc_id_o, 0);
        check("midrst_alloc_v", bus.fifo_alloc_v_o, 1);

        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_head = 0; m_tail = 0; m_occ = 0; deqs = 0; cyc = 0;
        while (deqs < 10000 && cyc < 60000) begin
            cyc++;
            check("rnd_alloc_v", bus.fifo_alloc_v_o, m_occ != N);
            check("rnd_alloc_id", bus.fifo_alloc_id_o, m_tail);
            check("rnd_empty", bus.empty_o, m_occ == 0);
            check("rnd_deq_v", bus.fifo_deq_v_o, m_valid[m_head]);
            a = (m_occ != N) && ($urandom_range(9) < 7);
            d = m_valid[m_head] && ($urandom_range(9) < 6);
            if (d) check("rnd_data", bus.fifo_deq_data_o, m_data[m_head]);
            cand.delete();
            for (int k = 0; k < m_occ; k++) begin
                e = (m_head + k) % N;
                if (!m_valid[e]) cand.push_back(e);
            end
            w = (cand.size() > 0) && ($urandom_range(3) != 0);
            wid = w ? cand[$urandom_range(cand.size() - 1)] : 0;
            bus.fifo_alloc_yumi_i = a;
            bus.fifo_deq_yumi_i   = d;
            bus.write_v_i         = w;
            bus.write_id_i        = 2'(wid);
            bus.write_data_i      = $urandom;
            if (d) begin
                m_valid[m_head] = 1'b0;
                m_head = (m_head + 1) % N;
                deqs++;
            end
            if (w) begin
                m_valid[wid] = 1'b1;
                m_data[wid]  = bus.write_data_i;
            end
            if (a) m_tail = (m_tail + 1) % N;
            m_occ = m_occ + int'(a) - int'(d);
            tick();
        end
        idle();
        check("rnd_deq_count", deqs, 10000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
